// File: rtl/autotune_pkg.sv
// Shared enums for the autotune pitch chain (resynthesis FSM and pending-request kind).
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package autotune_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOOP = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } pend_e;

endpackage

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// True dual-port, read-first, single-clock block RAM with optional output register.
// Latency: 1 cycle (LOW_LATENCY) or 2 cycles (HIGH_PERFORMANCE) from address to dout.
// Backpressure: none; reads/writes happen on every enabled cycle.
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int    RAM_WIDTH       = 18,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic [RAM_WIDTH-1:0]         dinb,
  input  logic                         clka,
  input  logic                         wea,
  input  logic                         web,
  input  logic                         ena,
  input  logic                         enb,
  input  logic                         rsta,
  input  logic                         rstb,
  input  logic                         regcea,
  input  logic                         regceb,
  output logic [RAM_WIDTH-1:0]         douta,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_a;
  logic [RAM_WIDTH-1:0] ram_data_b;

  // Both ports in one process: each returns the old word (read-first) then writes.
  always_ff @(posedge clka) begin
    if (ena) begin
      ram_data_a <= ram[addra];
      if (wea) ram[addra] <= dina;
    end
    if (enb) begin
      ram_data_b <= ram[addrb];
      if (web) ram[addrb] <= dinb;
    end
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
    assign douta = ram_data_a;
    assign doutb = ram_data_b;
  end else begin : g_high_performance
    logic [RAM_WIDTH-1:0] douta_q;
    logic [RAM_WIDTH-1:0] doutb_q;

    // Output register stage; holds when its clock enable is low.
    always_ff @(posedge clka) begin
      if (rsta)        douta_q <= '0;
      else if (regcea) douta_q <= ram_data_a;
      if (rstb)        doutb_q <= '0;
      else if (regceb) doutb_q <= ram_data_b;
    end

    assign douta = douta_q;
    assign doutb = doutb_q;
  end

endmodule

// File: rtl/period_resynth.sv
// Pitch resynthesis: replays the latest detected-period grain to build output periods of target length.
// Latency: valid_out exactly 2 cycles after each valid_in, in passthrough and loop alike.
// Backpressure: none; one output strobe per input strobe, back-to-back accepted.
module period_resynth
  import autotune_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int WINDOW_SIZE = 2048,
  parameter int MIN_PERIOD  = 16,
  parameter int MAX_PERIOD  = 1023
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [WIDTH-1:0]               sample_in,
  input  logic                           valid_in,
  input  logic [$clog2(WINDOW_SIZE)-1:0] tau_in,
  input  logic [$clog2(WINDOW_SIZE)-1:0] target_in,
  input  logic                           period_valid_in,
  output logic [WIDTH-1:0]               sample_out,
  output logic                           valid_out,
  output logic                           looping_out
);

  localparam int            AW       = $clog2(WINDOW_SIZE);
  localparam logic [AW-1:0] MIN_P    = AW'(MIN_PERIOD);
  localparam logic [AW-1:0] MAX_P    = AW'(MAX_PERIOD);
  localparam logic [AW:0]   FILL_MAX = (AW+1)'(WINDOW_SIZE);

  state_e        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW:0]   fill_q, fill_d;
  pend_e         pend_kind_q, pend_kind_d;
  logic [AW-1:0] pend_tau_q, pend_tau_d, pend_tgt_q, pend_tgt_d;
  logic [AW-1:0] tau_q, tau_d, tgt_q, tgt_d;
  logic [AW-1:0] start_q, start_d, g_q, g_d, k_q, k_d;

  pend_e         eff_kind;
  logic [AW-1:0] eff_tau, eff_tgt, cur_tau, cur_tgt, cur_start, cur_g;
  logic [AW-1:0] rd_addr, g_inc, k_inc;
  logic          req_ok, load, stop, boundary, looping, wr_en;
  state_e        cur_mode;

  logic             v1_q, v2_q;
  logic [WIDTH-1:0] p1_q, p2_q;
  state_e           m1_q, m2_q;
  logic [WIDTH-1:0] ram_dout, ram_douta_unused;

  assign req_ok = (tau_in >= MIN_P) && (tau_in <= MAX_P) &&
                  (target_in >= MIN_P) && (target_in <= MAX_P);
  assign wr_en  = valid_in && !rst_in;

  // Resolve the request seen this cycle and decide boundary / load / stop and the read address.
  always_comb begin
    eff_kind = pend_kind_q;
    eff_tau  = pend_tau_q;
    eff_tgt  = pend_tgt_q;
    if (period_valid_in) begin
      eff_kind = req_ok ? RUN : STOP;
      eff_tau  = tau_in;
      eff_tgt  = target_in;
    end
    load = 1'b0;
    stop = 1'b0;
    if (valid_in) begin
      if (state_q == IDLE) begin
        load = (eff_kind == RUN) && (fill_q >= {1'b0, eff_tau});
      end else if (k_q == '0) begin
        load = (eff_kind == RUN);
        stop = (eff_kind == STOP);
      end
    end
    boundary  = load || (valid_in && (state_q == LOOP) && (k_q == '0));
    looping   = load || (valid_in && (state_q == LOOP) && !stop);
    cur_tau   = load ? eff_tau : tau_q;
    cur_tgt   = load ? eff_tgt : tgt_q;
    cur_start = wp_q - cur_tau;
    cur_g     = boundary ? '0 : g_q;
    rd_addr   = (boundary ? cur_start : start_q) + cur_g;
    g_inc     = cur_g + 1'b1;
    k_inc     = k_q + 1'b1;
    cur_mode  = looping ? LOOP : IDLE;
  end

  // Next-state for the FSM, write side, pending request and grain/period counters.
  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    fill_d      = fill_q;
    pend_kind_d = eff_kind;
    pend_tau_d  = eff_tau;
    pend_tgt_d  = eff_tgt;
    tau_d       = tau_q;
    tgt_d       = tgt_q;
    start_d     = start_q;
    g_d         = g_q;
    k_d         = k_q;
    if (valid_in) begin
      wp_d = wp_q + 1'b1;
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    end
    if (load) pend_kind_d = NONE;
    if (looping) begin
      state_d = LOOP;
      tau_d   = cur_tau;
      tgt_d   = cur_tgt;
      if (boundary) start_d = cur_start;
      g_d = (g_inc == cur_tau) ? '0 : g_inc;
      k_d = (k_inc == cur_tgt) ? '0 : k_inc;
    end
    if (stop) begin
      state_d     = IDLE;
      pend_kind_d = NONE;
      g_d         = '0;
      k_d         = '0;
    end
  end

  // Control state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      fill_q      <= '0;
      pend_kind_q <= NONE;
      pend_tau_q  <= '0;
      pend_tgt_q  <= '0;
      tau_q       <= '0;
      tgt_q       <= '0;
      start_q     <= '0;
      g_q         <= '0;
      k_q         <= '0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      pend_kind_q <= pend_kind_d;
      pend_tau_q  <= pend_tau_d;
      pend_tgt_q  <= pend_tgt_d;
      tau_q       <= tau_d;
      tgt_q       <= tgt_d;
      start_q     <= start_d;
      g_q         <= g_d;
      k_q         <= k_d;
    end
  end

  // Two-stage strobe/passthrough/mode pipeline aligned with the BRAM read; stage 2 holds between strobes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      p1_q <= '0;
      p2_q <= '0;
      m1_q <= IDLE;
      m2_q <= IDLE;
    end else begin
      v1_q <= valid_in;
      v2_q <= v1_q;
      if (valid_in) begin
        p1_q <= sample_in;
        m1_q <= cur_mode;
      end
      if (v1_q) begin
        p2_q <= p1_q;
        m2_q <= m1_q;
      end
    end
  end

  xilinx_true_dual_port_read_first_1_clock_ram #(
    .RAM_WIDTH       (WIDTH),
    .RAM_DEPTH       (WINDOW_SIZE),
    .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
  ) u_buf (
    .addra  (wp_q),
    .addrb  (rd_addr),
    .dina   (sample_in),
    .dinb   ({WIDTH{1'b0}}),
    .clka   (clk_in),
    .wea    (wr_en),
    .web    (1'b0),
    .ena    (wr_en),
    .enb    (wr_en),
    .rsta   (rst_in),
    .rstb   (rst_in),
    .regcea (1'b0),
    .regceb (v1_q),
    .douta  (ram_douta_unused),
    .doutb  (ram_dout)
  );

  assign sample_out  = (m2_q == LOOP) ? ram_dout : p2_q;
  assign valid_out   = v2_q;
  assign looping_out = (state_q == LOOP);

endmodule

// File: tb/tb_period_resynth.sv
// Self-checking bench for period_resynth against a sample-history reference model.
// Latency: expects every output strobe exactly 2 cycles after its input strobe.
// Backpressure: none; stimulus mixes back-to-back and gapped strobes.
module tb_period_resynth;
  localparam int W  = 16;
  localparam int AW = 11;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [W-1:0]  sample_in;
  logic          valid_in;
  logic [AW-1:0] tau_in;
  logic [AW-1:0] target_in;
  logic          period_valid_in;
  logic [W-1:0]  sample_out;
  logic          valid_out;
  logic          looping_out;

  period_resynth dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_in       (sample_in),
    .valid_in        (valid_in),
    .tau_in          (tau_in),
    .target_in       (target_in),
    .period_valid_in (period_valid_in),
    .sample_out      (sample_out),
    .valid_out       (valid_out),
    .looping_out     (looping_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    int           cyc;
    logic [W-1:0] dat;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;
  logic [W-1:0] ramp_v;

  // Reference model: full input history since reset, indexed by absolute sample number.
  logic [W-1:0] hist[$];
  bit m_loop;
  int m_tau, m_tgt, m_base, m_j;
  int p_kind, p_tau, p_tgt;  // 0 none, 1 run, 2 stop

  always @(posedge clk_in) cyc++;
  always @(negedge clk_in) if (valid_out === 1'b1) obs_q.push_back(ev_t'{cyc, sample_out});

  task automatic model_step(input bit vld, input logic [W-1:0] s, input bit pv, input int tau, input int tgt);
    int n;
    logic [W-1:0] out;
    if (pv) begin
      if (tau >= 16 && tau <= 1023 && tgt >= 16 && tgt <= 1023) begin
        p_kind = 1; p_tau = tau; p_tgt = tgt;
      end else p_kind = 2;
    end
    if (!vld) return;
    n   = hist.size();
    out = s;
    if (!m_loop) begin
      if (p_kind == 1 && n >= p_tau) begin
        m_loop = 1; m_tau = p_tau; m_tgt = p_tgt; p_kind = 0; m_j = 0;
      end
    end else if (m_j == 0) begin
      if (p_kind == 1) begin
        m_tau = p_tau; m_tgt = p_tgt; p_kind = 0;
      end else if (p_kind == 2) begin
        m_loop = 0; p_kind = 0;
      end
    end
    if (m_loop) begin
      if (m_j == 0) m_base = n - m_tau;
      out = hist[m_base + (m_j % m_tau)];
      m_j = (m_j + 1) % m_tgt;
    end
    hist.push_back(s);
    exp_q.push_back(ev_t'{cyc + 2, out});
  endtask

  task automatic drive(input bit vld, input logic [W-1:0] s, input bit pv = 0, input int tau = 0, input int tgt = 0);
    @(negedge clk_in);
    valid_in        = vld;
    sample_in       = s;
    period_valid_in = pv;
    tau_in          = AW'(tau);
    target_in       = AW'(tgt);
    model_step(vld, s, pv, tau, tgt);
  endtask

  task automatic gap(input int n);
    repeat (n) drive(0, '0);
  endtask

  task automatic ramp(input int n, input bit gaps = 0);
    repeat (n) begin
      drive(1, ramp_v);
      ramp_v++;
      if (gaps && $urandom_range(3) == 0) gap($urandom_range(3, 1));
    end
  endtask

  task automatic do_reset();
    ev_t keep[$];
    @(negedge clk_in);
    rst_in          = 1'b1;
    valid_in        = 1'b0;
    period_valid_in = 1'b0;
    foreach (exp_q[i]) if (exp_q[i].cyc <= cyc) keep.push_back(exp_q[i]);
    exp_q = keep;
    hist.delete();
    m_loop = 0; m_j = 0; p_kind = 0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sample_out !== '0) begin errors++; $display("FAIL reset sample_out: got %h want 0", sample_out); end
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset valid_out: got %b want 0", valid_out); end
    checks++;
    if (looping_out !== 1'b0) begin errors++; $display("FAIL reset looping_out: got %b want 0", looping_out); end
  endtask

  task automatic test_passthrough();
    ev_t e, o;
    logic [W-1:0] last;
    do_reset();
    ramp_v = '0;
    ramp(200, 1);
    gap(4);
    last = ramp_v - 1'b1;
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : ev_t'{-1, 16'hxxxx};
      o = (obs_q.size() != 0) ? obs_q.pop_front() : ev_t'{-1, 16'hxxxx};
      checks++;
      if (o.cyc !== e.cyc || o.dat !== e.dat) begin
        errors++;
        $display("FAIL passthrough strobe: got cyc %0d dat %h, want cyc %0d dat %h", o.cyc, o.dat, e.cyc, e.dat);
      end
    end
    checks++;
    if (looping_out !== 1'b0) begin errors++; $display("FAIL passthrough looping_out: got %b want 0", looping_out); end
    checks++;
    if (sample_out !== last) begin errors++; $display("FAIL passthrough hold: got %h want %h", sample_out, last); end
  endtask

  task automatic test_equal_periods();
    ev_t e, o;
    do_reset();
    ramp_v = '0;
    ramp(300);
    drive(1, ramp_v, 1, 100, 100);
    ramp_v++;
    ramp(299);
    gap(4);
    checks++;
    if (looping_out !== 1'b1) begin errors++; $display("FAIL equal looping_out: got %b want 1", looping_out); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : ev_t'{-1, 16'hxxxx};
      o = (obs_q.size() != 0) ? obs_q.pop_front() : ev_t'{-1, 16'hxxxx};
      checks++;
      if (o.cyc !== e.cyc || o.dat !== e.dat) begin
        errors++;
        $display("FAIL equal strobe: got cyc %0d dat %h, want cyc %0d dat %h", o.cyc, o.dat, e.cyc, e.dat);
      end
    end
  endtask

  task automatic test_repetition();
    ev_t e, o;
    do_reset();
    ramp_v = '0;
    ramp(300);
    drive(0, '0, 1, 100, 150);
    ramp(450, 1);
    gap(4);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : ev_t'{-1, 16'hxxxx};
      o = (obs_q.size() != 0) ? obs_q.pop_front() : ev_t'{-1, 16'hxxxx};
      checks++;
      if (o.cyc !== e.cyc || o.dat !== e.dat) begin
        errors++;
        $display("FAIL repeat strobe: got cyc %0d dat %h, want cyc %0d dat %h", o.cyc, o.dat, e.cyc, e.dat);
      end
    end
  endtask

  task automatic test_truncate_stop();
    ev_t e, o;
    do_reset();
    ramp_v = '0;
    ramp(300);
    drive(0, '0, 1, 100, 50);
    ramp(220, 1);
    checks++;
    if (looping_out !== 1'b1) begin errors++; $display("FAIL truncate looping_out: got %b want 1", looping_out); end
    drive(0, '0, 1, 0, 0);
    ramp(120, 1);
    gap(4);
    checks++;
    if (looping_out !== 1'b0) begin errors++; $display("FAIL stop looping_out: got %b want 0", looping_out); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : ev_t'{-1, 16'hxxxx};
      o = (obs_q.size() != 0) ? obs_q.pop_front() : ev_t'{-1, 16'hxxxx};
      checks++;
      if (o.cyc !== e.cyc || o.dat !== e.dat) begin
        errors++;
        $display("FAIL truncate_stop strobe: got cyc %0d dat %h, want cyc %0d dat %h", o.cyc, o.dat, e.cyc, e.dat);
      end
    end
  endtask

  task automatic test_fill_update();
    ev_t e, o;
    do_reset();
    ramp_v = '0;
    ramp(40);
    drive(0, '0, 1, 100, 100);
    ramp(60);
    gap(2);
    checks++;
    if (looping_out !== 1'b0) begin errors++; $display("FAIL fill gate looping_out: got %b want 0", looping_out); end
    ramp(1);
    gap(1);
    checks++;
    if (looping_out !== 1'b1) begin errors++; $display("FAIL fill enter looping_out: got %b want 1", looping_out); end
    ramp(30);
    drive(0, '0, 1, 100, 80);
    ramp(300, 1);
    gap(4);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : ev_t'{-1, 16'hxxxx};
      o = (obs_q.size() != 0) ? obs_q.pop_front() : ev_t'{-1, 16'hxxxx};
      checks++;
      if (o.cyc !== e.cyc || o.dat !== e.dat) begin
        errors++;
        $display("FAIL fill_update strobe: got cyc %0d dat %h, want cyc %0d dat %h", o.cyc, o.dat, e.cyc, e.dat);
      end
    end
  endtask

  task automatic test_reset_mid_loop();
    ev_t e, o;
    do_reset();
    ramp_v = '0;
    ramp(300);
    drive(1, ramp_v, 1, 64, 90);
    ramp_v++;
    ramp(149);
    do_reset();
    checks++;
    if (sample_out !== '0 || valid_out !== 1'b0 || looping_out !== 1'b0) begin
      errors++;
      $display("FAIL mid-loop reset outputs: got %h/%b/%b want 0/0/0", sample_out, valid_out, looping_out);
    end
    ramp(60, 1);
    gap(4);
    checks++;
    if (looping_out !== 1'b0) begin errors++; $display("FAIL resume looping_out: got %b want 0", looping_out); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : ev_t'{-1, 16'hxxxx};
      o = (obs_q.size() != 0) ? obs_q.pop_front() : ev_t'{-1, 16'hxxxx};
      checks++;
      if (o.cyc !== e.cyc || o.dat !== e.dat) begin
        errors++;
        $display("FAIL reset_mid_loop strobe: got cyc %0d dat %h, want cyc %0d dat %h", o.cyc, o.dat, e.cyc, e.dat);
      end
    end
  endtask

  function automatic int pick_period();
    case ($urandom_range(9))
      0:       return 0;
      1:       return $urandom_range(15, 1);
      2:       return $urandom_range(2047, 1024);
      3:       return 16;
      4:       return 1023;
      default: return $urandom_range(1023, 16);
    endcase
  endfunction

  task automatic test_random();
    ev_t e, o;
    bit  vld, pv;
    do_reset();
    repeat (1100) drive(1, W'($urandom));
    for (int i = 0; i < 2500; i++) begin
      vld = ($urandom_range(3) != 0);
      pv  = ($urandom_range(39) == 0);
      drive(vld, W'($urandom), pv, pick_period(), pick_period());
    end
    gap(4);
    checks++;
    if (looping_out !== m_loop) begin errors++; $display("FAIL random looping_out: got %b want %b", looping_out, m_loop); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : ev_t'{-1, 16'hxxxx};
      o = (obs_q.size() != 0) ? obs_q.pop_front() : ev_t'{-1, 16'hxxxx};
      checks++;
      if (o.cyc !== e.cyc || o.dat !== e.dat) begin
        errors++;
        $display("FAIL random strobe: got cyc %0d dat %h, want cyc %0d dat %h", o.cyc, o.dat, e.cyc, e.dat);
      end
    end
  endtask

  initial begin
    rst_in          = 1'b1;
    valid_in        = 1'b0;
    sample_in       = '0;
    tau_in          = '0;
    target_in       = '0;
    period_valid_in = 1'b0;
    ramp_v          = '0;
    m_loop = 0; m_tau = 0; m_tgt = 0; m_base = 0; m_j = 0;
    p_kind = 0; p_tau = 0; p_tgt = 0;
    test_reset();
    test_passthrough();
    test_equal_periods();
    test_repetition();
    test_truncate_stop();
    test_fill_update();
    test_reset_mid_loop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
